// File: rtl/scan_ctrl.sv
// Scan test sequencer: loads a pattern into an external scan chain, pulses one
// capture cycle, unloads the response and compares it against a masked expectation.
module scan_ctrl #(
  parameter int CHAIN_LEN = 32
) (
  input  logic                 CK,
  input  logic                 RESETN,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic [CHAIN_LEN-1:0] EXP_IN,
  input  logic [CHAIN_LEN-1:0] MASK_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [CHAIN_LEN-1:0] RESP
);

  localparam int CW = $clog2(CHAIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CAPT,
    UNLOAD,
    CMP
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [CHAIN_LEN-1:0] pat_sh;
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] mask_q;

  // Outputs are set one edge ahead so each cycle already sees its own SE/SI value.
  always_ff @(posedge CK or negedge RESETN) begin
    if (!RESETN) begin
      state  <= IDLE;
      cnt    <= '0;
      pat_sh <= '0;
      exp_q  <= '0;
      mask_q <= '0;
      SE     <= 1'b0;
      SI     <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      PASS   <= 1'b0;
      RESP   <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            state  <= SHIFT;
            cnt    <= '0;
            pat_sh <= PAT_IN << 1;
            exp_q  <= EXP_IN;
            mask_q <= MASK_IN;
            SE     <= 1'b1;
            SI     <= PAT_IN[CHAIN_LEN-1];
            BUSY   <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
            state <= CAPT;
            cnt   <= '0;
            SE    <= 1'b0;
            SI    <= 1'b0;
          end else begin
            cnt    <= cnt + 1'b1;
            SI     <= pat_sh[CHAIN_LEN-1];
            pat_sh <= pat_sh << 1;
          end
        end
        CAPT: begin
          state <= UNLOAD;
          cnt   <= '0;
          SE    <= 1'b1;
          SI    <= 1'b0;
        end
        UNLOAD: begin
          // The far end of the chain comes out first, so fill RESP from the top.
          RESP[LAST - cnt] <= SO;
          if (cnt == LAST) begin
            state <= CMP;
            cnt   <= '0;
            SE    <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CMP: begin
          PASS  <= (((RESP ^ exp_q) & ~mask_q) == '0);
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          SE    <= 1'b0;
          SI    <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
